// File: rtl/regfile_sb.sv
// Decode-stage register file: registered multi-port reads with writeback bypass,
// read hold, and a per-register busy scoreboard for hazard tracking.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                rsv,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                flush,
  output logic                busy_any
);

  logic [XLEN-1:0]     regs_q [NREG];
  logic [NREG-1:0]     busy_q, busy_d;
  logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]      rd_busy_q, rd_busy_d;
  logic                busy_any_q;
  logic                wr_ok;

  assign wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

  // Writeback clear, then reserve, then flush; later steps override earlier ones.
  always_comb begin
    busy_d = busy_q;
    if (we) busy_d[waddr] = 1'b0;
    if (rsv && !flush) busy_d[rsv_addr] = 1'b1;
    if (flush) busy_d = '0;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Reads see a same-cycle writeback but not a same-cycle reserve.
  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int i = 0; i < NRD; i++) begin
      if ((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0)) begin
        rd_data_d[i*XLEN +: XLEN] = '0;
      end else if (we && (waddr == rd_addr[i*AW +: AW])) begin
        rd_data_d[i*XLEN +: XLEN] = wdata;
      end else begin
        rd_data_d[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
      end
      rd_busy_d[i] = busy_q[rd_addr[i*AW +: AW]] & ~(we && (waddr == rd_addr[i*AW +: AW]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      busy_q     <= '0;
      busy_any_q <= 1'b0;
      rd_data_q  <= '0;
      rd_busy_q  <= '0;
    end else begin
      if (wr_ok) regs_q[waddr] <= wdata;
      busy_q     <= busy_d;
      busy_any_q <= |busy_d;
      if (rd_en) begin
        rd_data_q <= rd_data_d;
        rd_busy_q <= rd_busy_d;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_busy  = rd_busy_q;
  assign busy_any = busy_any_q;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with registered multi-port reads, write-to-read bypass, read hold (stall), and a per-register scoreboard of busy bits. It sits in the decode stage of the core pipeline. Decode reads source operands and their hazard status in one access and reserves its destination. Writeback clears the reservation and writes the result. Flush drops all outstanding reservations.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers; power of two, at least 2; AW = log2(NREG).
- NRD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- rd_en  in  1  read enable; when 0, rd_data and rd_busy hold.
- rd_addr  in  NRD*AW  packed read addresses; port i is bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  packed registered read data.
- rd_busy  out  NRD  registered busy flag per read port.
- we  in  1  writeback valid.
- waddr  in  AW  writeback address.
- wdata  in  XLEN  writeback data.
- rsv  in  1  reserve request from decode.
- rsv_addr  in  AW  register to mark busy.
- flush  in  1  clear all busy bits.
- busy_any  out  1  registered OR of all busy bits.

Decided: one clock; reset is synchronous and active-high.

## Operation
- Storage: NREG x XLEN data array plus NREG busy bits.
- Write: on we=1, reg[waddr] <= wdata. If ZERO_REG=1 and waddr=0, the write is dropped.
- Busy update order within a cycle, applied in sequence:
  - Writeback clears busy[waddr] when we=1.
  - Reserve sets busy[rsv_addr] when rsv=1 and flush=0. Reserve therefore wins over a same-cycle writeback to the same register.
  - flush=1 clears every busy bit; both the reserve and the writeback clear are superseded.
  - With ZERO_REG=1, busy[0] is held at 0.
- Read, when rd_en=1, for each port i with address a = rd_addr[i]:
  - rd_data[i] <= 0 if ZERO_REG=1 and a=0.
  - Otherwise rd_data[i] <= wdata if we=1 and waddr=a (bypass).
  - Otherwise rd_data[i] <= reg[a].
  - rd_busy[i] <= busy[a] & ~(we & waddr==a). A same-cycle writeback un-busies the register; a same-cycle reserve is not visible. Decode reads its sources before reserving its destination.
  - flush does not affect the rd_busy value sampled in the same cycle.
- When rd_en=0, rd_data and rd_busy keep their previous values. Writes, reserves and flush still take effect.
- busy_any <= OR of the next-state busy bits.
- All NRD ports are independent. Identical addresses on several ports return identical values.

## Timing
- Reset (rst=1 at an edge):
  - All registers, busy bits, rd_data, rd_busy and busy_any become 0.
  - we, rsv and flush are ignored in that cycle.
- Reset asserted mid-operation discards pending reservations. The first edge with rst=0 behaves normally.
- Read latency: 1 cycle. Address presented at edge N gives data valid after edge N+1's update, stable for cycle N+1.
- Write latency: 1 cycle. A read issued in the same cycle as the write sees the new value through the bypass. A read issued in the next cycle sees it from the array.
- Reserve/clear latency: 1 cycle. A reserve at edge N is seen by a read issued at cycle N+1.
- No handshake back-pressure. Every request is accepted every cycle.
- Address wrap: addresses are exactly AW bits wide, so no out-of-range case exists.

## Test plan
- Reset: load reg5=0xDEADBEEF and reserve r7, then pulse rst for one cycle. Reading r5 and r7 then returns rd_data=0, rd_busy=0, busy_any=0.
- Bypass: we=1, waddr=3, wdata=0x12345678 with rd_addr port0=3, port1=3 in the same cycle. Next cycle both ports return 0x12345678. A write of 0xFFFFFFFF to r0 followed by a read of r0 returns 0.
- Scoreboard: rsv r9 at cycle 0, then read r9 at cycle 1 returns rd_busy=1. At cycle 2, we to r9 with a read of r9 gives rd_busy=0 and data=wdata, and busy_any falls to 0.
- Simultaneous events: rsv r4 and we r4 in the same cycle leaves r4 busy afterwards. Reserve r4 and r6, then flush together with rsv r8: all busy bits are 0 and busy_any=0.
- Stall: read r2=0xA, then set rd_en=0 while writing r2=0xB and changing rd_addr. rd_data holds 0xA. Raising rd_en returns 0xB.
- Parameters: repeat the bypass and scoreboard scenarios with XLEN=64, NREG=64, NRD=3 and ZERO_REG=0. With ZERO_REG=0, r0 holds a written value and can be reserved.
